// File: rtl/identity_matrix_streamer_pkg.sv
// Shared definitions for the PCA matrix streamers: FSM state encoding,
// fixed-point helper and default matrix geometry shared with the memory unit.
package pca_pkg;

    localparam int unsigned PCA_N  = 4;
    localparam int unsigned PCA_DW = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } pca_state_t;

    // Fixed-point 1.0 for a DW-bit word with frac_bits fraction bits.
    function automatic logic [63:0] fx_one(input int unsigned dw, input int unsigned frac_bits);
        return (frac_bits < dw) ? (64'd1 << frac_bits) : 64'd0;
    endfunction

endpackage

// File: rtl/identity_matrix_streamer_if.sv
// Beat stream carrying one matrix in row-major order, LANES elements per beat.
interface identity_matrix_streamer_if
    import pca_pkg::*;
#(
    parameter int unsigned N     = PCA_N,
    parameter int unsigned DW    = PCA_DW,
    parameter int unsigned LANES = 1
) ();

    localparam int unsigned IW = $clog2(N);

    logic                  out_valid;
    logic                  out_ready;
    logic [LANES*DW-1:0]   out_data;
    logic [IW-1:0]         out_row;
    logic [IW-1:0]         out_col_base;
    logic                  out_row_last;
    logic                  out_last;

    modport master (
        output out_valid, out_data, out_row, out_col_base, out_row_last, out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_data, out_row, out_col_base, out_row_last, out_last,
        output out_ready
    );

endinterface

// File: rtl/identity_matrix_streamer_matrix_index_counter.sv
// Row/column position counter for row-major matrix streaming with a LANES
// column stride. Exposes the registered position plus its successor so a
// caller can precompute the payload of the next beat.
module matrix_index_counter
    import pca_pkg::*;
#(
    parameter int unsigned N     = PCA_N,
    parameter int unsigned LANES = 1,
    localparam int unsigned IW   = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          init,
    input  logic          en,
    output logic [IW-1:0] row,
    output logic [IW-1:0] col_base,
    output logic [IW-1:0] nxt_row,
    output logic [IW-1:0] nxt_col_base,
    output logic          row_last,
    output logic          last
);

    localparam logic [IW-1:0] COL_END = IW'(N - LANES);
    localparam logic [IW-1:0] ROW_END = IW'(N - 1);
    localparam logic [IW-1:0] STEP    = IW'(LANES);

    logic nxt_row_last;
    logic nxt_last;

    // Successor position: wrap the column at the row end and step the row.
    always_comb begin
        nxt_row      = row;
        nxt_col_base = col_base + STEP;
        if (col_base == COL_END) begin
            nxt_col_base = '0;
            nxt_row      = (row == ROW_END) ? '0 : row + 1'b1;
        end
    end

    assign nxt_row_last = (nxt_col_base == COL_END);
    assign nxt_last     = nxt_row_last && (nxt_row == ROW_END);

    // Position and end-of-row/matrix flags are registered together so the
    // flags read 0 whenever the counter is parked at the cleared state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row      <= '0;
            col_base <= '0;
            row_last <= 1'b0;
            last     <= 1'b0;
        end else if (clr) begin
            row      <= '0;
            col_base <= '0;
            row_last <= 1'b0;
            last     <= 1'b0;
        end else if (init) begin
            row      <= '0;
            col_base <= '0;
            row_last <= (COL_END == '0);
            last     <= 1'b0;
        end else if (en) begin
            row      <= nxt_row;
            col_base <= nxt_col_base;
            row_last <= nxt_row_last;
            last     <= nxt_last;
        end
    end

endmodule

// File: rtl/identity_matrix_streamer.sv
// Streams an N x N scaled identity matrix in row-major order, LANES elements
// per beat, over a valid/ready interface.
// Optional IDENTITY_SCALE_EN: adds scale_in, latched on accepted start as the
// diagonal value; otherwise the diagonal is the constant 1 << FRAC_BITS.
module identity_matrix_streamer
    import pca_pkg::*;
#(
    parameter int unsigned N         = PCA_N,
    parameter int unsigned DW        = PCA_DW,
    parameter int unsigned LANES     = 1,
    parameter int unsigned FRAC_BITS = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          abort,
`ifdef IDENTITY_SCALE_EN
    input  logic [DW-1:0]                 scale_in,
`endif
    identity_matrix_streamer_if.master    bus,
    output logic                          busy,
    output logic                          done
);

    localparam int unsigned   IW  = $clog2(N);
    localparam logic [DW-1:0] ONE = DW'(fx_one(DW, FRAC_BITS));

    generate
        if (N < 2) begin : g_chk_n
            $error("identity_matrix_streamer: N must be >= 2");
        end
        if (LANES < 1 || LANES > N || (N % LANES) != 0) begin : g_chk_lanes
            $error("identity_matrix_streamer: LANES must divide N and lie in 1..N");
        end
        if (FRAC_BITS >= DW) begin : g_chk_frac
            $error("identity_matrix_streamer: FRAC_BITS must be < DW");
        end
    endgenerate

    pca_state_t          state_q;
    logic                valid_q;
    logic                busy_q;
    logic                done_q;
    logic [LANES*DW-1:0] data_q;

    logic [IW-1:0] cnt_row;
    logic [IW-1:0] cnt_col;
    logic [IW-1:0] nxt_row;
    logic [IW-1:0] nxt_col;
    logic          cnt_row_last;
    logic          cnt_last;

    logic start_ok;
    logic xfer;
    logic cnt_clr;
    logic cnt_en;

    logic [DW-1:0] diag_start;
    logic [DW-1:0] diag_run;

`ifdef IDENTITY_SCALE_EN
    logic [DW-1:0] diag_q;

    // Diagonal captured on accepted start; later scale_in changes are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diag_q <= ONE;
        end else if (start_ok) begin
            diag_q <= scale_in;
        end
    end

    assign diag_start = scale_in;
    assign diag_run   = diag_q;
`else
    assign diag_start = ONE;
    assign diag_run   = ONE;
`endif

    // Lane k carries the diagonal when it sits on row == column.
    function automatic logic [LANES*DW-1:0] make_beat(
        input logic [IW-1:0] r,
        input logic [IW-1:0] c,
        input logic [DW-1:0] d
    );
        logic [LANES*DW-1:0] b;
        b = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            if (32'(r) == 32'(c) + k) begin
                b[k*DW +: DW] = d;
            end
        end
        return b;
    endfunction

    assign start_ok = (state_q == IDLE) && start && !abort;
    assign xfer     = (state_q == STREAM) && bus.out_ready && !abort;
    assign cnt_clr  = (state_q == STREAM) && (abort || (bus.out_ready && cnt_last));
    assign cnt_en   = xfer && !cnt_last;

    matrix_index_counter #(
        .N     (N),
        .LANES (LANES)
    ) u_index (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr          (cnt_clr),
        .init         (start_ok),
        .en           (cnt_en),
        .row          (cnt_row),
        .col_base     (cnt_col),
        .nxt_row      (nxt_row),
        .nxt_col_base (nxt_col),
        .row_last     (cnt_row_last),
        .last         (cnt_last)
    );

    // Control FSM; payload for the next beat is loaded on each transfer so
    // out_data lines up with the counter position it advances to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        state_q <= STREAM;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                        data_q  <= make_beat('0, '0, diag_start);
                    end
                end
                STREAM: begin
                    if (abort) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        data_q  <= '0;
                    end else if (bus.out_ready) begin
                        if (cnt_last) begin
                            state_q <= DONE;
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            data_q  <= '0;
                        end else begin
                            data_q <= make_beat(nxt_row, nxt_col, diag_run);
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    data_q  <= '0;
                end
            endcase
        end
    end

    assign bus.out_valid    = valid_q;
    assign bus.out_data     = data_q;
    assign bus.out_row      = cnt_row;
    assign bus.out_col_base = cnt_col;
    assign bus.out_row_last = cnt_row_last;
    assign bus.out_last     = cnt_last;
    assign busy             = busy_q;
    assign done             = done_q;

endmodule

// File: tb/tb_identity_matrix_streamer.sv
// Scoreboard bench: two streamers (LANES=1 and LANES=2, N=4) share stimulus;
// expected beats come from row-major index arithmetic on the identity matrix.
module tb_identity_matrix_streamer;
    import pca_pkg::*;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned IW = $clog2(N);
`ifdef IDENTITY_SCALE_EN
    localparam int unsigned FB = 16;
`else
    localparam int unsigned FB = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic          out_ready;
    logic [DW-1:0] scale_in;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    generate
        for (genvar g = 0; g < 2; g++) begin : g_inst
            localparam int unsigned L     = (g == 0) ? 1 : 2;
            localparam int unsigned BEATS = N * N / L;

            typedef struct {
                logic [L*DW-1:0] data;
                logic [IW-1:0]   row;
                logic [IW-1:0]   col;
                logic            rl;
                logic            last;
            } beat_t;

            identity_matrix_streamer_if #(.N(N), .DW(DW), .LANES(L)) sbus ();
            logic busy;
            logic done;
            logic outs_zero;

            assign sbus.out_ready = out_ready;

            identity_matrix_streamer #(
                .N         (N),
                .DW        (DW),
                .LANES     (L),
                .FRAC_BITS (FB)
            ) dut (
                .clk      (clk),
                .rst_n    (rst_n),
                .start    (start),
                .abort    (abort),
`ifdef IDENTITY_SCALE_EN
                .scale_in (scale_in),
`endif
                .bus      (sbus),
                .busy     (busy),
                .done     (done)
            );

            assign outs_zero = !sbus.out_valid && (sbus.out_data == '0) && (sbus.out_row == '0) &&
                               (sbus.out_col_base == '0) && !sbus.out_row_last && !sbus.out_last &&
                               !busy && !done;

            beat_t           q[$];
            beat_t           e;
            int              m_state = 0;
            logic            stall_prev = 1'b0;
            logic [L*DW-1:0] held_data;
            logic [IW-1:0]   held_row;
            logic [IW-1:0]   held_col;
            logic            held_rl;
            logic            held_last;
            logic [63:0]     dg;
            int              r;
            int              c;

            // Model of the expected stream plus decoupled output checker.
            always @(negedge clk) begin
                if (!rst_n) begin
                    q.delete();
                    m_state    = 0;
                    stall_prev = 1'b0;
                end else begin
                    check($sformatf("L%0d done", L), 64'(done), 64'(m_state == 2));
                    check($sformatf("L%0d valid", L), 64'(sbus.out_valid), 64'(m_state == 1));
                    check($sformatf("L%0d busy", L), 64'(busy), 64'(m_state == 1));
                    if (stall_prev && m_state == 1) begin
                        check($sformatf("L%0d hold data", L), 64'(sbus.out_data), 64'(held_data));
                        check($sformatf("L%0d hold pos", L),
                              64'({sbus.out_row, sbus.out_col_base, sbus.out_row_last, sbus.out_last}),
                              64'({held_row, held_col, held_rl, held_last}));
                    end
                    stall_prev = 1'b0;
                    case (m_state)
                        0: begin
                            if (start && !abort) begin
`ifdef IDENTITY_SCALE_EN
                                dg = 64'(scale_in);
`else
                                dg = 64'd1 << FB;
`endif
                                for (int b = 0; b < int'(BEATS); b++) begin
                                    r      = (b * int'(L)) / int'(N);
                                    c      = (b * int'(L)) % int'(N);
                                    e.data = '0;
                                    for (int k = 0; k < int'(L); k++) begin
                                        if (r == c + k) e.data[k*DW +: DW] = dg[DW-1:0];
                                    end
                                    e.row  = IW'(r);
                                    e.col  = IW'(c);
                                    e.rl   = (c == int'(N - L));
                                    e.last = (b == int'(BEATS) - 1);
                                    q.push_back(e);
                                end
                                m_state = 1;
                            end
                        end
                        1: begin
                            if (abort) begin
                                q.delete();
                                m_state = 0;
                            end else if (out_ready) begin
                                if (q.size() == 0) begin
                                    check($sformatf("L%0d extra beat", L), 64'd1, 64'd0);
                                end else begin
                                    e = q.pop_front();
                                    check($sformatf("L%0d data", L), 64'(sbus.out_data), 64'(e.data));
                                    check($sformatf("L%0d row", L), 64'(sbus.out_row), 64'(e.row));
                                    check($sformatf("L%0d col", L), 64'(sbus.out_col_base), 64'(e.col));
                                    check($sformatf("L%0d row_last", L), 64'(sbus.out_row_last), 64'(e.rl));
                                    check($sformatf("L%0d last", L), 64'(sbus.out_last), 64'(e.last));
                                    if (e.last) m_state = 2;
                                end
                            end else begin
                                stall_prev = 1'b1;
                                held_data  = sbus.out_data;
                                held_row   = sbus.out_row;
                                held_col   = sbus.out_col_base;
                                held_rl    = sbus.out_row_last;
                                held_last  = sbus.out_last;
                            end
                        end
                        default: m_state = 0;
                    endcase
                end
            end
        end
    endgenerate

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic all_idle();
        return !g_inst[0].busy && !g_inst[1].busy && !g_inst[0].done && !g_inst[1].done;
    endfunction

    task automatic wait_idle(input int budget);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (all_idle()) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check("idle timeout", 64'(ok), 64'd1);
    endtask

    task automatic check_first_beat(input string name);
        check({name, " L1 first"}, 64'({g_inst[0].sbus.out_valid, g_inst[0].sbus.out_row, g_inst[0].sbus.out_col_base}),
              64'({1'b1, 2'd0, 2'd0}));
        check({name, " L2 first"}, 64'({g_inst[1].sbus.out_valid, g_inst[1].sbus.out_row, g_inst[1].sbus.out_col_base}),
              64'({1'b1, 2'd0, 2'd0}));
    endtask

    initial begin
        start     = 1'b0;
        abort     = 1'b0;
        out_ready = 1'b1;
        scale_in  = 32'h0002_0000;
        rst_n     = 1'b0;
        #12;
        check("reset L1 zero", 64'(g_inst[0].outs_zero), 64'd1);
        check("reset L2 zero", 64'(g_inst[1].outs_zero), 64'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        tick();

        // Full-rate matrix
        start = 1'b1;
        tick();
        start = 1'b0;
        check_first_beat("fullrate");
        wait_idle(100);
        tick();

        // Random back-pressure, scale_in change and ignored start mid-stream
        scale_in = 32'h0002_0000;
        start    = 1'b1;
        tick();
        start = 1'b0;
        begin
            logic ok;
            ok = 1'b0;
            for (int i = 0; i < 400; i++) begin
                out_ready = 1'($urandom_range(0, 1));
                if (i == 3) scale_in = $urandom;
                start = (i == 5);
                tick();
                if (all_idle()) begin
                    ok = 1'b1;
                    break;
                end
            end
            check("random idle timeout", 64'(ok), 64'd1);
        end
        start     = 1'b0;
        out_ready = 1'b1;
        tick();

        // abort with start in IDLE, and abort alone in IDLE
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("abort+start idle", 64'({g_inst[0].sbus.out_valid, g_inst[1].sbus.out_valid}), 64'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort idle", 64'({g_inst[0].busy, g_inst[1].busy}), 64'd0);

        // Abort at beat 6, restart two cycles later
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        check("beat6 row/col", 64'({g_inst[0].sbus.out_row, g_inst[0].sbus.out_col_base}), 64'({2'd1, 2'd2}));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort drop", 64'({g_inst[0].sbus.out_valid, g_inst[1].sbus.out_valid}), 64'd0);
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check_first_beat("restart");
        wait_idle(100);
        tick();

        // Asynchronous reset at beat 9
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        #2 rst_n = 1'b0;
        #1;
        check("midreset L1 zero", 64'(g_inst[0].outs_zero), 64'd1);
        check("midreset L2 zero", 64'(g_inst[1].outs_zero), 64'd1);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("no resume", 64'({g_inst[0].sbus.out_valid, g_inst[1].sbus.out_valid}), 64'd0);

        // Clean matrix after reset
        start = 1'b1;
        tick();
        start = 1'b0;
        check_first_beat("postreset");
        wait_idle(100);
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
